cas_buffer_arbiter: RTL and testbench

- Shares the single byte-wide CAS buffer port (DDRAM-backed byte buffer: addr/din/dout/we/rd/ready) between two requesters:
  - the OSD CAS loader, which writes during download;
  - the tape player, which reads during playback.
- Owns all buffer strobes and generates loader back-pressure (ioctl_wait contribution) and the player read-data handshake.
- Adds request capture, loader priority, a watchdog and a rewind flush so neither requester has to track buffer timing.

---
 rtl/cas_buf_pkg.sv | 28 ++
 rtl/cas_req_latch.sv | 42 ++++
 rtl/cas_buffer_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_cas_buffer_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cas_buf_pkg.sv
// Shared types and defaults for the CAS buffer arbiter.
package cas_buf_pkg;

  localparam int unsigned ADDR_W_DEF  = 27;
  localparam int unsigned TIMEOUT_DEF = 4095;

  // Arbiter sequencing: issue states strobe the buffer, wait states watch mem_ready.
  typedef enum logic [2:0] {
    IDLE,
    W_ISSUE,
    W_WAIT,
    R_ISSUE,
    R_WAIT
  } state_e;

  // Requester currently holding the buffer port.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_LD,
    OWN_PL
  } owner_e;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cas_req_latch.sv
// One-entry request holder: captures address/data on set, drops the pending
// flag on clear. A set in the same cycle as a clear wins, so a fresh request
// arriving while the previous one is being issued is never lost.
module cas_req_latch #(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_set,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_pend,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  logic              r_pend;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  // Capture or overwrite on set; otherwise clear retires the entry.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pend <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (i_set) begin
      r_pend <= 1'b1;
      r_addr <= i_addr;
      r_data <= i_data;
    end else if (i_clr) begin
      r_pend <= 1'b0;
    end
  end

  assign o_pend = r_pend;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/cas_buffer_arbiter.sv
// Shares the byte-wide CAS buffer between the download loader (writes) and the
// tape player (reads). The loader always wins; a watchdog bounds every buffer
// operation and a rewind flush suppresses the result of an in-flight read.
module cas_buffer_arbiter
  import cas_buf_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  // Loader side
  input  logic              i_ld_active,
  input  logic              i_ld_wr,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [7:0]        i_ld_data,
  output logic              o_ld_wait,
  // Player side
  input  logic              i_pl_rd,
  input  logic [ADDR_W-1:0] i_pl_addr,
  output logic [7:0]        o_pl_data,
  output logic              o_pl_valid,
  input  logic              i_flush,
  // Buffer side
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_din,
  output logic              o_mem_we,
  output logic              o_mem_rd,
  input  logic [7:0]        i_mem_dout,
  input  logic              i_mem_ready,
  // Status
  output logic              o_busy,
  output logic              o_timeout_err
);

  localparam int unsigned CntW = cnt_width(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e            r_state;
  owner_e            r_owner;
  logic [CntW-1:0]   r_wd_cnt;
  logic              r_discard;
  logic              r_mem_we;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_din;
  logic [7:0]        r_pl_data;
  logic              r_pl_valid;
  logic              r_timeout_err;

  logic              w_ld_pend;
  logic [ADDR_W-1:0] w_ld_addr;
  logic [7:0]        w_ld_data;
  logic              w_ld_set;
  logic              w_ld_clr;
  logic              w_pl_pend;
  logic [ADDR_W-1:0] w_pl_addr;
  logic              w_pl_data_unused;
  logic              w_pl_set;
  logic              w_pl_clr;
  logic              w_pl_issue;
  logic              w_in_read;
  logic              w_wait_done;
  logic              w_drop_read;

  // Back-pressure covers both a held write and a write owning the bus.
  assign o_ld_wait = w_ld_pend | (r_owner == OWN_LD);

  // A write strobe while back-pressured is a loader protocol error: drop it.
  assign w_ld_set = i_ld_wr & ~o_ld_wait;
  assign w_ld_clr = (r_state == IDLE) & w_ld_pend;

  // Player requests are refused during download; flush beats a same-cycle request.
  assign w_pl_set   = i_pl_rd & ~i_ld_active & ~i_flush;
  assign w_pl_issue = (r_state == IDLE) & ~w_ld_pend & w_pl_pend & ~i_ld_active & i_mem_ready;
  assign w_pl_clr   = w_pl_issue | i_flush;

  assign w_in_read   = (r_state == R_ISSUE) | (r_state == R_WAIT);
  // The buffer drops ready a cycle late, so the first wait cycle is never trusted.
  assign w_wait_done = (r_wd_cnt != '0) & i_mem_ready;
  assign w_drop_read = r_discard | i_flush;

  cas_req_latch #(
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_ld_latch (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_set   (w_ld_set),
    .i_clr   (w_ld_clr),
    .i_addr  (i_ld_addr),
    .i_data  (i_ld_data),
    .o_pend  (w_ld_pend),
    .o_addr  (w_ld_addr),
    .o_data  (w_ld_data)
  );

  // The player carries no data; its data lane is a tied-off single bit.
  cas_req_latch #(
    .ADDR_W (ADDR_W),
    .DATA_W (1)
  ) u_pl_latch (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_set   (w_pl_set),
    .i_clr   (w_pl_clr),
    .i_addr  (i_pl_addr),
    .i_data  (1'b0),
    .o_pend  (w_pl_pend),
    .o_addr  (w_pl_addr),
    .o_data  (w_pl_data_unused)
  );

  // Arbitration FSM with registered buffer strobes, read data and watchdog.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_owner       <= OWN_NONE;
      r_wd_cnt      <= '0;
      r_discard     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_din     <= '0;
      r_pl_data     <= 8'h00;
      r_pl_valid    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_mem_we   <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_pl_valid <= 1'b0;

      if (i_flush && w_in_read) begin
        r_discard <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_ld_pend) begin
            r_state    <= W_ISSUE;
            r_owner    <= OWN_LD;
            r_mem_we   <= 1'b1;
            r_mem_addr <= w_ld_addr;
            r_mem_din  <= w_ld_data;
          end else if (w_pl_issue) begin
            r_state    <= R_ISSUE;
            r_owner    <= OWN_PL;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= w_pl_addr;
            // A flush racing the issue still lets the read run, but mutes it.
            r_discard  <= i_flush;
          end
        end

        W_ISSUE: begin
          r_state  <= W_WAIT;
          r_wd_cnt <= '0;
        end

        R_ISSUE: begin
          r_state  <= R_WAIT;
          r_wd_cnt <= '0;
        end

        W_WAIT, R_WAIT: begin
          if (w_wait_done) begin
            if ((r_state == R_WAIT) && !w_drop_read) begin
              r_pl_data  <= i_mem_dout;
              r_pl_valid <= 1'b1;
            end
            r_state <= IDLE;
            r_owner <= OWN_NONE;
          end else if (r_wd_cnt == CntLast) begin
            // Abandon the operation; an aborted write is simply lost.
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
            r_owner       <= OWN_NONE;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_owner <= OWN_NONE;
        end
      endcase
    end
  end

  assign o_mem_we      = r_mem_we;
  assign o_mem_rd      = r_mem_rd;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_din     = r_mem_din;
  assign o_pl_data     = r_pl_data;
  assign o_pl_valid    = r_pl_valid;
  assign o_busy        = (r_state != IDLE);
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_cas_buffer_arbiter.sv
// Bench for cas_buffer_arbiter: a behavioural byte buffer with configurable
// ready delay, directed scenarios and a randomized download/readback check.
module tb_cas_buffer_arbiter;

  localparam int AW = 27;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ld_active = 1'b0;
  logic          ld_wr = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [7:0]    ld_data = '0;
  logic          ld_wait;
  logic          pl_rd = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [7:0]    pl_data;
  logic          pl_valid;
  logic          flush = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic          mem_rd;
  logic [7:0]    mem_dout = '0;
  logic          mem_ready = 1'b1;
  logic          busy;
  logic          timeout_err;

  int vectors = 0;
  int miscompares = 0;

  // Buffer model state
  logic [7:0] mem [0:1023];
  int         wr_cnt [0:1023];
  bit         init_done = 1'b0;
  bit         clr_cnt = 1'b0;
  bit         rand_mode = 1'b0;
  bit         hang = 1'b0;
  int         delay_cfg = 0;
  int         rem = 0;
  int         dly;
  int         we_pulses = 0;
  int         rd_pulses = 0;
  int         pv_pulses = 0;

  logic [7:0] exp_dl [0:999];
  logic [7:0] last_pl;

  cas_buffer_arbiter #(
    .ADDR_W  (AW),
    .TIMEOUT (TO)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_ld_active   (ld_active),
    .i_ld_wr       (ld_wr),
    .i_ld_addr     (ld_addr),
    .i_ld_data     (ld_data),
    .o_ld_wait     (ld_wait),
    .i_pl_rd       (pl_rd),
    .i_pl_addr     (pl_addr),
    .o_pl_data     (pl_data),
    .o_pl_valid    (pl_valid),
    .i_flush       (flush),
    .o_mem_addr    (mem_addr),
    .o_mem_din     (mem_din),
    .o_mem_we      (mem_we),
    .o_mem_rd      (mem_rd),
    .i_mem_dout    (mem_dout),
    .i_mem_ready   (mem_ready),
    .o_busy        (busy),
    .o_timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Byte buffer: ready drops the cycle after a strobe and stays low for the
  // configured number of cycles; hang keeps it low indefinitely.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) begin
        mem[i]    <= 8'($urandom);
        wr_cnt[i] <= 0;
      end
      init_done <= 1'b1;
    end
    if (clr_cnt) begin
      for (int i = 0; i < 1024; i++) wr_cnt[i] <= 0;
    end
    if (mem_we === 1'b1) begin
      mem[mem_addr[9:0]]    <= mem_din;
      wr_cnt[mem_addr[9:0]] <= wr_cnt[mem_addr[9:0]] + 1;
      we_pulses             <= we_pulses + 1;
    end
    if (mem_rd === 1'b1) begin
      mem_dout  <= mem[mem_addr[9:0]];
      rd_pulses <= rd_pulses + 1;
    end
    if (pl_valid === 1'b1) pv_pulses <= pv_pulses + 1;
    if (mem_we === 1'b1 || mem_rd === 1'b1) begin
      dly = rand_mode ? int'($urandom_range(0, 6)) : delay_cfg;
      if (hang) begin
        mem_ready <= 1'b0;
        rem       <= 0;
      end else if (dly > 0) begin
        mem_ready <= 1'b0;
        rem       <= dly - 1;
      end
    end else if (!hang && !mem_ready) begin
      if (rem > 0) rem <= rem - 1;
      else mem_ready <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Completion edge (counted from the capture edge) for a buffer that stays
  // busy for d cycles: capture, issue, at least two wait cycles, buffer time.
  function automatic int done_edge(input int d);
    return (3 + d > 4) ? 3 + d : 4;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((busy || ld_wait) && n < 200) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'(busy | ld_wait), 32'd0);
  endtask

  task automatic do_write(input int a, input logic [7:0] d, input bit with_pl);
    int n = 0;
    while (ld_wait && n < 100) begin
      tick();
      n++;
    end
    chk("ld_wait_release", 32'(ld_wait), 32'd0);
    ld_wr   = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    pl_rd   = with_pl;
    pl_addr = AW'(a);
    tick();
    ld_wr = 1'b0;
    pl_rd = 1'b0;
  endtask

  task automatic do_read(input int a, output int lat, output int npv, output logic [7:0] got);
    pl_rd   = 1'b1;
    pl_addr = AW'(a);
    tick();
    pl_rd = 1'b0;
    lat = -1;
    npv = 0;
    got = 8'h00;
    for (int k = 0; k < 30; k++) begin
      if (pl_valid) begin
        npv++;
        if (lat < 0) lat = k;
        got = pl_data;
      end
      tick();
    end
  endtask

  initial begin
    int nwe, nrd, npv, we_k, rd_k, pv_k, lat, addr, d, rd0, pv0;
    logic [7:0] got;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ld_wait", 32'(ld_wait), 32'd0);
    chk("rst_pl_valid", 32'(pl_valid), 32'd0);
    chk("rst_pl_data", 32'(pl_data), 32'h00);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", 32'(mem_din), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    tick();
    tick();

    // Single write with a 3-cycle buffer
    delay_cfg = 3;
    ld_wr = 1'b1; ld_addr = AW'(32'h10); ld_data = 8'hA5;
    tick();
    ld_wr = 1'b0;
    nwe = 0;
    for (int k = 0; k < 9; k++) begin
      chk("wr_ld_wait", 32'(ld_wait), 32'(k < done_edge(3)));
      if (mem_we) begin
        nwe++;
        chk("wr_we_cycle", 32'(k), 32'd1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h10);
        chk("wr_mem_din", 32'(mem_din), 32'hA5);
      end
      tick();
    end
    chk("wr_we_count", 32'(nwe), 32'd1);
    chk("wr_buffer_byte", 32'(mem[10'h10]), 32'hA5);
    chk("wr_addr_hold", 32'(mem_addr), 32'h10);
    chk("wr_din_hold", 32'(mem_din), 32'hA5);

    // Single read from a zero-delay buffer
    delay_cfg = 0;
    do_write(32'h20, 8'h3C, 1'b0);
    wait_idle();
    rd0 = rd_pulses;
    do_read(32'h20, lat, npv, got);
    chk("rd_strobes", 32'(rd_pulses - rd0), 32'd1);
    chk("rd_valid_pulses", 32'(npv), 32'd1);
    chk("rd_latency", 32'(lat), 32'd4);
    chk("rd_data", 32'(got), 32'h3C);

    // Loader and player requests in the same cycle
    do_write(6, 8'h77, 1'b0);
    wait_idle();
    ld_wr = 1'b1; ld_addr = AW'(5); ld_data = 8'h11;
    pl_rd = 1'b1; pl_addr = AW'(6);
    tick();
    ld_wr = 1'b0; pl_rd = 1'b0;
    we_k = -1; rd_k = -1; pv_k = -1;
    for (int k = 0; k < 14; k++) begin
      if (mem_we && we_k < 0) we_k = k;
      if (mem_rd && rd_k < 0) rd_k = k;
      if (pl_valid && pv_k < 0) begin
        pv_k = k;
        got  = pl_data;
      end
      tick();
    end
    chk("col_we_cycle", 32'(we_k), 32'd1);
    chk("col_rd_cycle", 32'(rd_k), 32'(done_edge(0) + 1));
    chk("col_pv_cycle", 32'(pv_k), 32'(done_edge(0) + 1 + done_edge(0) - 1));
    chk("col_rd_data", 32'(got), 32'h77);
    chk("col_wr_byte", 32'(mem[5]), 32'h11);

    // Download over a random-delay buffer with player reads being refused
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    rand_mode = 1'b1;
    ld_active = 1'b1;
    rd0 = rd_pulses;
    pv0 = pv_pulses;
    for (int i = 0; i < 1000; i++) begin
      exp_dl[i] = 8'($urandom);
      do_write(i, exp_dl[i], ($urandom_range(0, 7) == 0));
    end
    wait_idle();
    ld_active = 1'b0;
    rand_mode = 1'b0;
    repeat (6) tick();
    chk("dl_no_reads", 32'(rd_pulses - rd0), 32'd0);
    chk("dl_no_valid", 32'(pv_pulses - pv0), 32'd0);
    for (int i = 0; i < 1000; i++) begin
      chk("dl_write_count", 32'(wr_cnt[i]), 32'd1);
      chk("dl_byte", 32'(mem[i]), 32'(exp_dl[i]));
    end

    // Random readback with varying buffer delay
    last_pl = 8'h00;
    for (int j = 0; j < 20; j++) begin
      d = int'($urandom_range(0, 5));
      addr = int'($urandom_range(0, 999));
      delay_cfg = d;
      do_read(addr, lat, npv, got);
      chk("rnd_valid_pulses", 32'(npv), 32'd1);
      chk("rnd_latency", 32'(lat), 32'(done_edge(d)));
      chk("rnd_data", 32'(got), 32'(exp_dl[addr]));
      last_pl = exp_dl[addr];
      wait_idle();
    end

    // Flush while the read is waiting on the buffer
    delay_cfg = 5;
    rd0 = rd_pulses;
    pl_rd = 1'b1; pl_addr = AW'((32'h3 + 32'(last_pl)) % 1000);
    tick();
    pl_rd = 1'b0;
    npv = 0;
    for (int k = 0; k < 16; k++) begin
      flush = (k == 2);
      if (pl_valid) npv++;
      tick();
    end
    flush = 1'b0;
    chk("fl_bus_read", 32'(rd_pulses - rd0), 32'd1);
    chk("fl_no_valid", 32'(npv), 32'd0);
    chk("fl_data_kept", 32'(pl_data), 32'(last_pl));
    chk("fl_idle", 32'(busy), 32'd0);

    // Watchdog: buffer never returns ready
    hang = 1'b1;
    pl_rd = 1'b1; pl_addr = AW'(7);
    tick();
    pl_rd = 1'b0;
    npv = 0;
    for (int k = 0; k < 21; k++) begin
      if (k == 2 + TO - 1) chk("wd_before", 32'(timeout_err), 32'd0);
      if (k == 2 + TO) begin
        chk("wd_flag", 32'(timeout_err), 32'd1);
        chk("wd_busy", 32'(busy), 32'd0);
      end
      if (pl_valid) npv++;
      tick();
    end
    chk("wd_no_valid", 32'(npv), 32'd0);
    chk("wd_data_kept", 32'(pl_data), 32'(last_pl));
    hang = 1'b0;
    repeat (3) tick();

    // Asynchronous reset in the middle of a read wait
    delay_cfg = 8;
    pl_rd = 1'b1; pl_addr = AW'(9);
    tick();
    pl_rd = 1'b0;
    repeat (3) tick();
    chk("ar_busy_before", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_timeout_err", 32'(timeout_err), 32'd0);
    chk("ar_pl_data", 32'(pl_data), 32'h00);
    chk("ar_mem_addr", 32'(mem_addr), 32'd0);
    chk("ar_mem_rd", 32'(mem_rd), 32'd0);
    chk("ar_ld_wait", 32'(ld_wait), 32'd0);
    tick();
    reset = 1'b0;
    repeat (12) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_time_limit: observed no completion expected $finish");
    $fatal(1, "time limit");
  end

endmodule
